alu_rsp_unit: RTL

//  Clocked request/response responder around the combinational alu: accepts operand/op requests on a

---
 rtl/riscv_pkg.sv | 15 +
 rtl/alu.sv | 43 ++++
 rtl/alu_rsp_fifo.sv | 38 +++
 rtl/alu_rsp_unit.sv | 81 ++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: datapath width, alu opcodes and flag layout shared by the alu response unit
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int ALU_FLAGS_W = 4;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;
  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;
endpackage

// File: rtl/alu.sv
// alu: combinational integer alu with zero/negative/carry/overflow flags
import riscv_pkg::*;
module alu (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  alu_op_e         op_i,
  output logic [XLEN-1:0] result_o,
  output alu_flags_t      flags_o
);
  logic [XLEN:0] w_sum, w_diff;
  logic [$clog2(XLEN)-1:0] w_sh;
  assign w_sum  = {1'b0, a_i} + {1'b0, b_i};
  assign w_diff = {1'b0, a_i} + {1'b0, ~b_i} + (XLEN+1)'(1);
  assign w_sh   = b_i[$clog2(XLEN)-1:0];
  // SUB carry is the no-borrow bit: set when a >= b unsigned
  always_comb begin
    result_o = '0;
    flags_o  = '0;
    case (op_i)
      ALU_ADD: begin
        result_o         = w_sum[XLEN-1:0];
        flags_o.carry    = w_sum[XLEN];
        flags_o.overflow = (a_i[XLEN-1] == b_i[XLEN-1]) && (w_sum[XLEN-1] != a_i[XLEN-1]);
      end
      ALU_SUB: begin
        result_o         = w_diff[XLEN-1:0];
        flags_o.carry    = w_diff[XLEN];
        flags_o.overflow = (a_i[XLEN-1] != b_i[XLEN-1]) && (w_diff[XLEN-1] != a_i[XLEN-1]);
      end
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLL:  result_o = a_i << w_sh;
      ALU_SRL:  result_o = a_i >> w_sh;
      ALU_SRA:  result_o = $signed(a_i) >>> w_sh;
      ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      default:  result_o = '0;
    endcase
    flags_o.zero     = result_o == '0;
    flags_o.negative = result_o[XLEN-1];
  end
endmodule

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: synchronous response fifo with occupancy count and zeroed head when empty
module alu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  assign w_pop   = pop_i && valid_o;
  assign valid_o = r_count != '0;
  assign count_o = r_count;
  assign data_o  = valid_o ? r_mem[r_rptr] : '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push_i) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, w_pop};
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wptr] <= data_i;
  end
endmodule

// File: rtl/alu_rsp_unit.sv
// alu_rsp_unit: valid/ready request stage feeding the alu, results queued in an in-order response fifo
import riscv_pkg::*;
module alu_rsp_unit #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [XLEN-1:0]        req_a_i,
  input  logic [XLEN-1:0]        req_b_i,
  input  alu_op_e                req_op_i,
  input  logic [TAG_W-1:0]       req_tag_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [XLEN-1:0]        rsp_result_o,
  output alu_flags_t             rsp_flags_o,
  output logic [TAG_W-1:0]       rsp_tag_o,
  output logic [$clog2(DEPTH):0] rsp_count_o,
  output logic [31:0]            op_count_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = XLEN + ALU_FLAGS_W + TAG_W;
  logic                r_run, r_s1_valid;
  logic [XLEN-1:0]     r_a, r_b;
  alu_op_e             r_op;
  logic [TAG_W-1:0]    r_tag;
  logic [31:0]         r_op_count;
  logic [XLEN-1:0]     w_result;
  alu_flags_t          w_flags;
  logic [DW-1:0]       w_head;
  logic [CW:0]         w_fill;
  logic                w_accept, w_pop;
  // S1 always holds a reserved fifo slot, so its write can never overflow
  assign w_fill      = {1'b0, rsp_count_o} + {{CW{1'b0}}, r_s1_valid};
  assign req_ready_o = r_run && (w_fill < (CW+1)'(DEPTH));
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_pop       = rsp_valid_o && rsp_ready_i;
  assign op_count_o  = r_op_count;
  // r_run releases reset synchronously: ready rises on the first edge after rst_ni deasserts
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_run      <= 1'b0;
      r_s1_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= ALU_ADD;
      r_tag      <= '0;
      r_op_count <= '0;
    end else begin
      r_run      <= 1'b1;
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_a   <= req_a_i;
        r_b   <= req_b_i;
        r_op  <= req_op_i;
        r_tag <= req_tag_i;
      end
      if (w_pop) r_op_count <= r_op_count + 32'd1;
    end
  end
  alu u_alu (
    .a_i      (r_a),
    .b_i      (r_b),
    .op_i     (r_op),
    .result_o (w_result),
    .flags_o  (w_flags)
  );
  alu_rsp_fifo #(.DEPTH(DEPTH), .W(DW)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (r_s1_valid),
    .data_i  ({w_result, w_flags, r_tag}),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .valid_o (rsp_valid_o),
    .count_o (rsp_count_o)
  );
  assign {rsp_result_o, rsp_flags_o, rsp_tag_o} = w_head;
endmodule
